fpu_result_uart_tx: RTL and testbench

UART 8N1 transmitter that returns half-precision FPU results to the host over the same serial link the FPU receive path uses. It accepts one DATA_W-bit result word through a valid/ready handshake and serialises it as DATA_W/8 consecutive byte frames. The bit period is set at run time by CLKS_PER_BIT, the same value that drives the receiver. It sits beside the FPU FSM top; its serial output drives an output-enabled user IO pad.

---
 rtl/fpu_uart_pkg.sv | 17 +
 rtl/fpu_result_uart_tx.sv | 142 ++++++++++++++
 tb/tb_fpu_result_uart_tx.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/fpu_uart_pkg.sv
// Shared definitions for the FPU serial result path: transmit states and 8N1 framing constants.
package fpu_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_DONE
  } tx_state_e;

  localparam int   UART_DATA_BITS       = 8;
  localparam int   UART_STOP_BITS       = 1;
  localparam logic UART_IDLE_LEVEL      = 1'b1;
  localparam int   DEFAULT_CLKS_PER_BIT = 348;

endpackage

// File: rtl/fpu_result_uart_tx.sv
// UART 8N1 transmitter that sends one DATA_W-bit FPU result as DATA_W/8 back-to-back byte frames.
module fpu_result_uart_tx
  import fpu_uart_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CPB_W     = 16
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic [CPB_W-1:0]  CLKS_PER_BIT,
  input  logic [DATA_W-1:0] i_result,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_Tx_Serial,
  output logic              o_Tx_Active,
  output logic              o_Tx_Done
);

  localparam int NBYTES = DATA_W / 8;
  localparam int BI_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  tx_state_e         state, state_n;
  logic [CPB_W-1:0]  cnt, cnt_n;
  logic [CPB_W-1:0]  cpb, cpb_n;
  logic [2:0]        bit_idx, bit_idx_n;
  logic [BI_W-1:0]   byte_idx, byte_idx_n;
  logic [DATA_W-1:0] word, word_n;
  logic              serial_n, active_n, done_n, ready_n;
  logic              bit_end;

  // Picks bit b of the byte that goes out in slot bi, honouring the byte order.
  function automatic logic tx_bit(input logic [DATA_W-1:0] w, input logic [BI_W-1:0] bi,
                                  input logic [2:0] b);
    int                sh;
    logic [DATA_W-1:0] t;
    sh = MSB_FIRST ? (NBYTES - 1 - int'(bi)) * 8 : int'(bi) * 8;
    t  = w >> (sh + int'(b));
    return t[0];
  endfunction

  function automatic logic [CPB_W-1:0] sanitize_cpb(input logic [CPB_W-1:0] v);
    return (v == '0) ? CPB_W'(1) : v;
  endfunction

  assign bit_end = (cnt == cpb - CPB_W'(1));

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    cpb_n      = cpb;
    bit_idx_n  = bit_idx;
    byte_idx_n = byte_idx;
    word_n     = word;
    case (state)
      ST_IDLE: begin
        if (i_valid && o_ready) begin
          word_n     = i_result;
          cpb_n      = sanitize_cpb(CLKS_PER_BIT);
          cnt_n      = '0;
          bit_idx_n  = '0;
          byte_idx_n = '0;
          state_n    = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = ST_DATA;
        end else begin
          cnt_n = cnt + CPB_W'(1);
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_n = '0;
          if (bit_idx == 3'(UART_DATA_BITS - 1)) state_n = ST_STOP;
          else bit_idx_n = bit_idx + 3'd1;
        end else begin
          cnt_n = cnt + CPB_W'(1);
        end
      end
      ST_STOP: begin
        // Next start bit follows the stop bit with no gap.
        if (bit_end) begin
          cnt_n = '0;
          if (byte_idx == BI_W'(NBYTES - 1)) begin
            state_n = ST_DONE;
          end else begin
            byte_idx_n = byte_idx + BI_W'(1);
            state_n    = ST_START;
          end
        end else begin
          cnt_n = cnt + CPB_W'(1);
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so every port comes straight from a flop.
    serial_n = UART_IDLE_LEVEL;
    case (state_n)
      ST_START: serial_n = ~UART_IDLE_LEVEL;
      ST_DATA:  serial_n = tx_bit(word_n, byte_idx_n, bit_idx_n);
      default:  serial_n = UART_IDLE_LEVEL;
    endcase
    active_n = (state_n == ST_START) || (state_n == ST_DATA) || (state_n == ST_STOP);
    done_n   = (state_n == ST_DONE);
    ready_n  = (state_n == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      cpb         <= CPB_W'(1);
      bit_idx     <= '0;
      byte_idx    <= '0;
      o_Tx_Serial <= UART_IDLE_LEVEL;
      o_Tx_Active <= 1'b0;
      o_Tx_Done   <= 1'b0;
      o_ready     <= 1'b1;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      cpb         <= cpb_n;
      bit_idx     <= bit_idx_n;
      byte_idx    <= byte_idx_n;
      o_Tx_Serial <= serial_n;
      o_Tx_Active <= active_n;
      o_Tx_Done   <= done_n;
      o_ready     <= ready_n;
    end
  end

  always_ff @(posedge clk) begin
    word <= word_n;
  end

endmodule

// File: tb/tb_fpu_result_uart_tx.sv
// Bench for fpu_result_uart_tx: MSB-first and LSB-first instances against a frame-level line model.
module tb_fpu_result_uart_tx;

  localparam int DATA_W = 16;
  localparam int CPB_W  = 16;
  localparam int NB     = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst_l;
  logic [CPB_W-1:0]  cpb_in;
  logic [DATA_W-1:0] result;
  logic              valid;
  logic              ready_m, ser_m, act_m, done_m;
  logic              ready_l, ser_l, act_l, done_l;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fpu_result_uart_tx #(.DATA_W(DATA_W), .MSB_FIRST(1'b1), .CPB_W(CPB_W)) dut_m (
    .clk(clk), .rst_l(rst_l), .CLKS_PER_BIT(cpb_in), .i_result(result), .i_valid(valid),
    .o_ready(ready_m), .o_Tx_Serial(ser_m), .o_Tx_Active(act_m), .o_Tx_Done(done_m)
  );

  fpu_result_uart_tx #(.DATA_W(DATA_W), .MSB_FIRST(1'b0), .CPB_W(CPB_W)) dut_l (
    .clk(clk), .rst_l(rst_l), .CLKS_PER_BIT(cpb_in), .i_result(result), .i_valid(valid),
    .o_ready(ready_l), .o_Tx_Serial(ser_l), .o_Tx_Active(act_l), .o_Tx_Done(done_l)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] byte_at(input logic [15:0] w, input bit msb, input int b);
    return msb ? w[(NB - 1 - b) * 8 +: 8] : w[b * 8 +: 8];
  endfunction

  // status = {line, active, ready, done}
  task automatic chk_status(input string tag, input logic [3:0] exp_m, input logic [3:0] exp_l);
    chk({tag, "_m"}, 32'({ser_m, act_m, ready_m, done_m}), 32'(exp_m));
    chk({tag, "_l"}, 32'({ser_l, act_l, ready_l, done_l}), 32'(exp_l));
  endtask

  // Sends one word and checks the line every cycle from accept until back in idle.
  task automatic xfer(input logic [15:0] w, input logic [15:0] c, input bit disturb,
                      input bit keep, input logic [15:0] nw, input logic [15:0] nc,
                      input int abort_at);
    int         ce, len, mid, base;
    bit         exp_m[$], exp_l[$], cap_m[$], cap_l[$];
    logic [7:0] bm, bl, rm, rl;
    ce  = (c == 16'd0) ? 1 : int'(c);
    len = 10 * NB * ce;
    for (int b = 0; b < NB; b++) begin
      bm = byte_at(w, 1'b1, b);
      bl = byte_at(w, 1'b0, b);
      for (int s = 0; s < 10; s++) begin
        for (int r = 0; r < ce; r++) begin
          exp_m.push_back((s == 0) ? 1'b0 : (s == 9) ? 1'b1 : bm[s-1]);
          exp_l.push_back((s == 0) ? 1'b0 : (s == 9) ? 1'b1 : bl[s-1]);
        end
      end
    end

    result = w;
    cpb_in = c;
    valid  = 1'b1;
    @(posedge clk); #1;
    if (!keep) valid = 1'b0;
    for (int k = 1; k <= len; k++) begin
      cap_m.push_back(ser_m);
      cap_l.push_back(ser_l);
      chk("line_m", 32'(ser_m), 32'(exp_m[k-1]));
      chk("line_l", 32'(ser_l), 32'(exp_l[k-1]));
      chk("busy_m", 32'({act_m, ready_m, done_m}), 32'(3'b100));
      chk("busy_l", 32'({act_l, ready_l, done_l}), 32'(3'b100));
      if (abort_at == k) begin
        rst_l = 1'b0;
        @(posedge clk); #1;
        chk_status("abort", 4'b1010, 4'b1010);
        rst_l = 1'b1;
        return;
      end
      if (disturb && k == len / 2) begin
        valid  = 1'b1;
        result = 16'h1234;
        cpb_in = 16'd10;
      end
      if (disturb && k == len / 2 + 1) valid = 1'b0;
      @(posedge clk); #1;
    end
    chk_status("done", 4'b1001, 4'b1001);
    if (keep) begin
      result = nw;
      cpb_in = nc;
    end
    @(posedge clk); #1;
    chk_status("idle", 4'b1010, 4'b1010);

    // Receiver model: sample each bit in its middle and rebuild the bytes.
    mid = ce / 2;
    for (int f = 0; f < NB; f++) begin
      base = f * 10 * ce;
      for (int j = 0; j < 8; j++) begin
        rm[j] = cap_m[base + (1 + j) * ce + mid];
        rl[j] = cap_l[base + (1 + j) * ce + mid];
      end
      chk("rx_start_m", 32'(cap_m[base + mid]), 32'd0);
      chk("rx_byte_m", 32'(rm), 32'(byte_at(w, 1'b1, f)));
      chk("rx_byte_l", 32'(rl), 32'(byte_at(w, 1'b0, f)));
      chk("rx_stop_l", 32'(cap_l[base + 9 * ce + mid]), 32'd1);
    end
  endtask

  initial begin
    rst_l  = 1'b0;
    valid  = 1'b1;
    result = 16'($urandom);
    cpb_in = 16'd4;
    repeat (5) begin
      @(posedge clk); #1;
      chk_status("reset", 4'b1010, 4'b1010);
    end
    valid = 1'b0;
    rst_l = 1'b1;
    @(posedge clk); #1;
    chk_status("post_reset", 4'b1010, 4'b1010);

    xfer(16'h3C00, 16'd4, 1'b0, 1'b0, 16'h0, 16'h0, 0);
    xfer(16'hA55A, 16'd2, 1'b0, 1'b0, 16'h0, 16'h0, 0);
    xfer(16'h0001, 16'd3, 1'b0, 1'b1, 16'hFFFF, 16'd3, 0);
    xfer(16'hFFFF, 16'd3, 1'b0, 1'b0, 16'h0, 16'h0, 0);
    xfer(16'hBEEF, 16'd4, 1'b1, 1'b0, 16'h0, 16'h0, 0);
    xfer(16'h7E81, 16'd0, 1'b0, 1'b0, 16'h0, 16'h0, 0);

    xfer(16'hC3A5, 16'd3, 1'b0, 1'b0, 16'h0, 16'h0, 37);
    @(posedge clk); #1;
    chk_status("after_abort", 4'b1010, 4'b1010);
    xfer(16'h5AC3, 16'd3, 1'b0, 1'b0, 16'h0, 16'h0, 0);

    for (int i = 0; i < 8; i++) begin
      xfer(16'($urandom), 16'($urandom_range(0, 5)), bit'($urandom_range(0, 1)),
           1'b0, 16'h0, 16'h0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
